// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID decoupling queue.
package if_id_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    // One fetched {PC, instruction} pair as stored in the queue.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_entry_t;

    // Bubble presented to decode while the queue is empty.
    localparam if_id_entry_t BUBBLE = '{pc: RESET_PC, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_queue.sv
// In-order IF->ID decoupling queue with flush; fetch_ready freezes the PC when full.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AW-1:0]           IF_PC,
    input  logic [AW-1:0]           IF_instr,
    input  logic                    IF_valid,
    output logic                    fetch_ready,
    output logic                    ID_valid,
    output logic [AW-1:0]           ID_PC,
    output logic [AW-1:0]           ID_instr,
    input  logic                    ID_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if_id_entry_t mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          enq_c;
    logic          deq_c;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          fetch_ready_nxt;
    logic          id_valid_nxt;
    if_id_entry_t  wr_entry;
    if_id_entry_t  head_nxt;

    // Handshake qualification; flush overrides both sides.
    always_comb begin
        enq_c = IF_valid && fetch_ready && !flush;
        deq_c = ID_valid && ID_ready && !flush;
    end

    // Incoming pair, widened to the storage format.
    always_comb begin
        wr_entry       = BUBBLE;
        wr_entry.pc    = XLEN'(IF_PC);
        wr_entry.instr = XLEN'(IF_instr);
    end

    // Next pointer and occupancy.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (enq_c) begin
                wr_ptr_nxt = wr_ptr + PW'(1);
            end
            if (deq_c) begin
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Next registered status and head; a write landing on the new head slot is forwarded.
    always_comb begin
        fetch_ready_nxt = (count_nxt != CW'(DEPTH));
        id_valid_nxt    = (count_nxt != CW'(0));
        head_nxt        = BUBBLE;
        if (count_nxt != CW'(0)) begin
            if (enq_c && (rd_ptr_nxt == wr_ptr)) begin
                head_nxt = wr_entry;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers, occupancy and registered ID-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_ready <= 1'b1;
            ID_valid    <= 1'b0;
            ID_PC       <= AW'(RESET_PC);
            ID_instr    <= AW'(NOP_INSTR);
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            fetch_ready <= fetch_ready_nxt;
            ID_valid    <= id_valid_nxt;
            ID_PC       <= AW'(head_nxt.pc);
            ID_instr    <= AW'(head_nxt.instr);
        end
    end

endmodule
